// File: rtl/fp16_sqrt_seq.sv
// Purpose : upstream sequencer for the FP16 sqrt unit; loads an operand onto the shared
//           bus, holds ENABLE through the computation, and captures the result and flags.
// Latency : accept edge E -> OUT_VALID at E+3 (special operands) or E+13 (finite operands).
// Backpr. : IN_READY only in IDLE; OUT_VALID/OUT_DATA/flags held until OUT_READY.
//
// Ports: CLK/RESET (async active-high); IN_VALID/IN_READY/IN_DATA operand port;
//        OUT_VALID/OUT_READY/OUT_DATA + OUT_NAN/OUT_PINF/OUT_NINF/OUT_TIMEOUT result port;
//        SQ_DATA (shared tri-state bus), SQ_ENABLE, SQ_RESULT, SQ_IS_* to/from the sqrt unit.
// Build option: define FP16_SQRT_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles
//        with a NaN result (OUT_TIMEOUT=1); undefined, WAIT lasts until SQ_RESULT.
module fp16_sqrt_seq #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] OUT_DATA,
  output logic        OUT_NAN,
  output logic        OUT_PINF,
  output logic        OUT_NINF,
  output logic        OUT_TIMEOUT,
  inout  wire  [15:0] SQ_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_RESULT,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_IS_NINF
);

  // The wait counter is 6 bits wide, so the abort threshold must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 63) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..63");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] op_q;
  logic [15:0] res_q;
  logic        nan_q, pinf_q, ninf_q;
  logic        accept, capture, bus_drv;

`ifdef FP16_SQRT_TIMEOUT_EN
  logic [5:0]  wcnt_q;
  logic        tmo_q;
  logic        abort;
`endif

  // Next-state and per-state outputs.
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    SQ_ENABLE = 1'b0;
    OUT_VALID = 1'b0;
    bus_drv   = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
`ifdef FP16_SQRT_TIMEOUT_EN
    abort     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The unit samples the bus at the edge ending this cycle; the driver
        // is released at that same edge, one cycle before the unit drives back.
        SQ_ENABLE = 1'b1;
        bus_drv   = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        SQ_ENABLE = 1'b1;
        if (SQ_RESULT) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
`ifdef FP16_SQRT_TIMEOUT_EN
        else if (wcnt_q == 6'(TIMEOUT_CYCLES - 1)) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        // ENABLE low here clears the unit and guarantees a low gap between ops.
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch and result capture registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_q   <= '0;
      res_q  <= '0;
      nan_q  <= 1'b0;
      pinf_q <= 1'b0;
      ninf_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= IN_DATA;
      end
      if (capture) begin
        res_q  <= SQ_DATA;
        nan_q  <= SQ_IS_NAN;
        pinf_q <= SQ_IS_PINF;
        ninf_q <= SQ_IS_NINF;
      end
`ifdef FP16_SQRT_TIMEOUT_EN
      else if (abort) begin
        res_q  <= 16'hFE00;
        nan_q  <= 1'b1;
        pinf_q <= 1'b0;
        ninf_q <= 1'b0;
      end
`endif
    end
  end

`ifdef FP16_SQRT_TIMEOUT_EN
  // Counter restarts in LOAD (i.e. on entry to WAIT) and counts WAIT cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (state_q == ST_LOAD) begin
        wcnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wcnt_q <= wcnt_q + 6'd1;
      end
      if (capture) begin
        tmo_q <= 1'b0;
      end else if (abort) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign OUT_TIMEOUT = tmo_q;
`else
  assign OUT_TIMEOUT = 1'b0;
`endif

  assign OUT_DATA = res_q;
  assign OUT_NAN  = nan_q;
  assign OUT_PINF = pinf_q;
  assign OUT_NINF = ninf_q;

  // Bus is driven only in LOAD; released everywhere else.
  assign SQ_DATA = bus_drv ? op_q : 16'hzzzz;

endmodule

// File: tb/tb_fp16_sqrt_seq.sv
module tb_fp16_sqrt_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [15:0] IN_DATA = 16'h0000;
  logic        IN_READY, OUT_VALID, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT, SQ_ENABLE;
  logic [15:0] OUT_DATA;
  wire  [15:0] SQ_DATA;
  logic        SQ_RESULT = 1'b0;
  logic        SQ_IS_NAN = 1'b0;
  logic        SQ_IS_PINF = 1'b0;
  logic        SQ_IS_NINF = 1'b0;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 CLK = ~CLK;

  fp16_sqrt_seq dut (
    .CLK(CLK), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_NAN(OUT_NAN), .OUT_PINF(OUT_PINF), .OUT_NINF(OUT_NINF), .OUT_TIMEOUT(OUT_TIMEOUT),
    .SQ_DATA(SQ_DATA), .SQ_ENABLE(SQ_ENABLE), .SQ_RESULT(SQ_RESULT),
    .SQ_IS_NAN(SQ_IS_NAN), .SQ_IS_PINF(SQ_IS_PINF), .SQ_IS_NINF(SQ_IS_NINF)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural sqrt unit ----------------
  // Samples the bus on the first enabled edge, answers 2 edges later for special
  // operands and 12 edges later otherwise; ENABLE low clears it.
  logic        u_busy = 1'b0, u_drive = 1'b0, stub = 1'b0, ninf_inj = 1'b0;
  logic        m_spec = 1'b0, m_nan = 1'b0, m_pinf = 1'b0, m_ninf = 1'b0;
  logic [15:0] u_res = 16'h0000;
  int          u_cnt = 0;

  assign SQ_DATA = u_drive ? u_res : 16'hzzzz;

  // Returns {special, nan, pinf, ninf, result}.
  function automatic logic [19:0] unit_model(input logic [15:0] x);
    if (x[14:0] == 15'd0)                        return {4'b1000, x};
    else if (x[14:10] == 5'h1f && x[9:0] != 0)  return {4'b1100, x};
    else if (x[15])                              return {4'b1100, 16'hFE00};
    else if (x[14:10] == 5'h1f)                  return {4'b1010, x};
    else begin
      case (x)
        16'h4400: return {4'b0000, 16'h4000};
        16'h3C00: return {4'b0000, 16'h3C00};
        16'h4C00: return {4'b0000, 16'h4400};
        default:  return {4'b0000, 16'h0000};
      endcase
    end
  endfunction

  always @(posedge CLK) begin
    if (!SQ_ENABLE) begin
      u_busy <= 1'b0; u_drive <= 1'b0; SQ_RESULT <= 1'b0;
      SQ_IS_NAN <= 1'b0; SQ_IS_PINF <= 1'b0; SQ_IS_NINF <= 1'b0;
    end else if (!u_busy) begin
      u_busy <= 1'b1;
      u_cnt  <= 1;
      {m_spec, m_nan, m_pinf, m_ninf, u_res} <= unit_model(SQ_DATA);
    end else if (!stub) begin
      u_cnt <= u_cnt + 1;
      if (u_cnt + 1 == (m_spec ? 2 : 12)) begin
        u_drive    <= 1'b1;
        SQ_RESULT  <= 1'b1;
        SQ_IS_NAN  <= m_nan;
        SQ_IS_PINF <= m_pinf;
        SQ_IS_NINF <= m_ninf | ninf_inj;
      end
    end
  end

  // Invariants sampled every cycle outside reset.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (u_drive) chk("bus_contention", SQ_DATA, u_res);
      chk("in_ready_only_idle", 16'(IN_READY), 16'(!(SQ_ENABLE || OUT_VALID)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [15:0] d, output int n);
    @(negedge CLK);
    chk("in_ready_before_send", 16'(IN_READY), 16'h1);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    chk("load_enable", 16'(SQ_ENABLE), 16'h1);
    chk("load_bus", SQ_DATA, d);
    n = 0;
    while (!OUT_VALID && n < 64) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  // exp_f = {nan, pinf, ninf, timeout}
  task automatic recv(input string tag, input logic [15:0] exp_d, input logic [3:0] exp_f,
                      input int hold);
    chk({tag, "_valid"}, 16'(OUT_VALID), 16'h1);
    chk({tag, "_data"}, OUT_DATA, exp_d);
    chk({tag, "_flags"}, {12'h000, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT}, {12'h000, exp_f});
    chk({tag, "_done_enable"}, 16'(SQ_ENABLE), 16'h0);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      chk({tag, "_hold_valid"}, 16'(OUT_VALID), 16'h1);
      chk({tag, "_hold_data"}, OUT_DATA, exp_d);
      chk({tag, "_hold_flags"}, {12'h000, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT},
          {12'h000, exp_f});
      chk({tag, "_hold_in_ready"}, 16'(IN_READY), 16'h0);
      chk({tag, "_hold_enable"}, 16'(SQ_ENABLE), 16'h0);
    end
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk({tag, "_valid_drop"}, 16'(OUT_VALID), 16'h0);
    chk({tag, "_back_idle"}, 16'(IN_READY), 16'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #12;
    chk("rst_in_ready", 16'(IN_READY), 16'h1);
    chk("rst_out_valid", 16'(OUT_VALID), 16'h0);
    chk("rst_out_data", OUT_DATA, 16'h0000);
    chk("rst_flags", {12'h000, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT}, 16'h0000);
    chk("rst_enable", 16'(SQ_ENABLE), 16'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // sqrt(4.0) = 2.0, finite latency
    send(16'h4400, lat); chk("lat_4p0", 16'(lat), 16'd13);
    recv("sqrt4", 16'h4000, 4'b0000, 0);

    // signed zeros
    send(16'h0000, lat); chk("lat_pzero", 16'(lat), 16'd3);
    recv("pzero", 16'h0000, 4'b0000, 0);
    send(16'h8000, lat); chk("lat_nzero", 16'(lat), 16'd3);
    recv("nzero", 16'h8000, 4'b0000, 0);

    // negative -> NaN, +inf, NaN passthrough
    send(16'hBC00, lat); chk("lat_neg", 16'(lat), 16'd3);
    recv("neg1", 16'hFE00, 4'b1000, 0);
    send(16'h7C00, lat); chk("lat_pinf", 16'(lat), 16'd3);
    recv("pinf", 16'h7C00, 4'b0100, 0);
    send(16'h7E00, lat); chk("lat_nan", 16'(lat), 16'd3);
    recv("nanpass", 16'h7E00, 4'b1000, 0);

    // consumer stalls 5 cycles
    send(16'h3C00, lat); chk("lat_1p0", 16'(lat), 16'd13);
    recv("stall", 16'h3C00, 4'b0000, 5);

    // NINF flag capture path
    ninf_inj = 1'b1;
    send(16'h4C00, lat); chk("lat_16p0", 16'(lat), 16'd13);
    recv("ninf", 16'h4400, 4'b0010, 0);
    ninf_inj = 1'b0;

    // reset while waiting aborts the op
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_DATA  = 16'h4400;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midrst_enable", 16'(SQ_ENABLE), 16'h0);
    chk("midrst_out_valid", 16'(OUT_VALID), 16'h0);
    chk("midrst_out_data", OUT_DATA, 16'h0000);
    chk("midrst_in_ready", 16'(IN_READY), 16'h1);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      chk("midrst_no_result", 16'(OUT_VALID), 16'h0);
    end
    send(16'h4400, lat); chk("lat_after_rst", 16'(lat), 16'd13);
    recv("after_rst", 16'h4000, 4'b0000, 0);

`ifdef FP16_SQRT_TIMEOUT_EN
    // unit never answers -> abort after 32 WAIT cycles
    stub = 1'b1;
    send(16'h3C00, lat); chk("lat_timeout", 16'(lat), 16'd33);
    recv("timeout", 16'hFE00, 4'b1001, 0);
    stub = 1'b0;
    send(16'h4400, lat); chk("lat_post_tmo", 16'(lat), 16'd13);
    recv("post_tmo", 16'h4000, 4'b0000, 0);
`endif

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
